pattern_sweep_ctrl: RTL
=======================

PATTERN_SWEEP_CTRL -- requirements
Module: pattern_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 4, meaning cycles each vector is held before sampling y (legal 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin a sweep; accepted only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous abort of a running sweep.
REQ-006 SHALL have port exp_tt  input  8  expected truth table; bit k = expected y for {a,b,c}=k.
REQ-007 SHALL have port y  input  1  response of the 3-input DUT.
REQ-008 SHALL have ports a, b, c  output  1 each  stimulus to DUT; {a,b,c} = current vector index.
REQ-009 SHALL have port busy  output  1  high in DRIVE and SAMPLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-011 SHALL have port err_cnt  output  4  number of mismatching vectors in the last sweep (0..8).
REQ-012 SHALL have port fail_mask  output  8  bit k set when vector k mismatched.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-014 IDLE: start=1 and abort=0 -> DRIVE; idx<=0; settle count<=0; exp_tt captured into internal register; err_cnt and fail_mask cleared.
REQ-015 DRIVE: {a,b,c}=idx; stays SETTLE cycles (counter 0..SETTLE-1), then -> SAMPLE.
REQ-016 SAMPLE: one cycle; {a,b,c} still idx; if y != captured exp_tt[idx] then fail_mask[idx]<=1 and err_cnt<=err_cnt+1.
REQ-017 SAMPLE with idx<7 -> DRIVE, idx<=idx+1, counter<=0; idx==7 -> DONE (no wrap to 0).
REQ-018 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-019 Latency: done high in cycle 8*(SETTLE+1)+1 counted from the edge that accepts start (41 for SETTLE=4).
REQ-020 {a,b,c}=000 in IDLE and DONE.
REQ-021 start while busy or in DONE SHALL be ignored; exp_tt changes after capture SHALL not affect the sweep.
REQ-022 abort=1 in DRIVE or SAMPLE -> IDLE next cycle, no done pulse, no mismatch recorded that cycle; err_cnt/fail_mask hold partial results.
REQ-023 start and abort both high in IDLE: abort wins, stays IDLE.
REQ-024 err_cnt and fail_mask SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, idx=0, counter=0, a=b=c=0, busy=0, done=0, err_cnt=0, fail_mask=0, captured table=0.
REQ-026 Reset mid-sweep SHALL discard all progress; no done pulse follows reset release.
REQ-027 First start is accepted on the first rising edge with rst_n=1.

Configuration
REQ-028 Macro PATTERN_SWEEP_LOG_EN SHALL, when defined, add outputs log_valid (1) and log_data (5): log_valid pulses in each SAMPLE cycle (not on the aborting cycle), log_data = {idx[2:0], y, mismatch}.
REQ-029 Without PATTERN_SWEEP_LOG_EN the log ports and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 SETTLE=4, exp_tt=8'h80, DUT=AND3, start pulse -> done in cycle 41, err_cnt=0, fail_mask=8'h00, abc steps 000..111 each held 5 cycles.
REQ-031 exp_tt=8'h80, DUT=OR3 -> err_cnt=6, fail_mask=8'h7E.
REQ-032 abort asserted in cycle 12 after start (vector 2 in DRIVE) -> IDLE next cycle, no done, fail_mask bits 2..7 = 0.
REQ-033 rst_n low mid-sweep at vector 5 -> all outputs 0 immediately (asynchronous); new start runs a full 41-cycle sweep.
REQ-034 start re-pulsed during busy and exp_tt changed to 8'hFF mid-sweep -> sweep unaffected, single done, results per original table.
REQ-035 With PATTERN_SWEEP_LOG_EN, DUT=AND3, exp_tt=8'h80 -> exactly 8 log_valid pulses; final log_data = 5'b11110.

Source files
------------

// File: rtl/pattern_sweep_ctrl.sv
// Exhaustive 3-input truth-table sweeper: drives {a,b,c}, samples y, logs mismatches.
// Optional sample log port enabled by defining PATTERN_SWEEP_LOG_EN.
module pattern_sweep_ctrl #(
   parameter int SETTLE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] exp_tt,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic [3:0] err_cnt,
   output logic [7:0] fail_mask
`ifdef PATTERN_SWEEP_LOG_EN
   ,
   output logic       log_valid,
   output logic [4:0] log_data
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  tt_q, tt_d;
   logic [3:0]  err_q, err_d;
   logic [7:0]  mask_q, mask_d;
   logic        miss;

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         tt_q    <= '0;
         err_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         tt_q    <= tt_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
      end
   end

   // Next-state logic: settle each vector, sample once, advance or finish.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      tt_d    = tt_q;
      err_d   = err_q;
      mask_d  = mask_q;
      miss    = (y != tt_q[idx_q]);
      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = DRIVE;
               idx_d   = '0;
               cnt_d   = '0;
               tt_d    = exp_tt;
               err_d   = '0;
               mask_d  = '0;
            end
         end
         DRIVE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (cnt_q == 8'(SETTLE - 1)) begin
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         SAMPLE: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               if (miss) begin
                  mask_d[idx_q] = 1'b1;
                  err_d         = err_q + 4'd1;
               end
               if (idx_q == 3'd7) begin
                  state_d = DONE;
               end else begin
                  state_d = DRIVE;
                  idx_d   = idx_q + 3'd1;
                  cnt_d   = '0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore outputs; stimulus is parked at 000 outside the active sweep.
   always_comb begin
      busy      = (state_q == DRIVE) || (state_q == SAMPLE);
      done      = (state_q == DONE);
      {a, b, c} = busy ? idx_q : 3'b000;
      err_cnt   = err_q;
      fail_mask = mask_q;
   end

`ifdef PATTERN_SWEEP_LOG_EN
   // One log record per completed sample; suppressed on an aborting cycle.
   always_comb begin
      log_valid = (state_q == SAMPLE) && !abort;
      log_data  = {idx_q, y, miss};
   end
`endif

endmodule
